// File: rtl/phase_a_seq.sv
// Iteration sequencer for the radix-78 Montgomery reduction stage phase_a.
// Pulses phase_a once per step, captures new_a, and builds each next operand from a digit stream.
module phase_a_seq #(
    parameter int SIZE    = 3072,
    parameter int RADIX   = 78,
    parameter int ITER_W  = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ITER_W-1:0]     n_iter,
    input  logic [SIZE+RADIX:0]   a_init,
    input  logic [RADIX:0]        digit,
    input  logic                  digit_valid,
    output logic                  digit_ready,
    output logic                  pa_en,
    output logic [SIZE+RADIX:0]   pa_a,
    input  logic [SIZE-1:0]       pa_new_a,
    input  logic                  pa_en_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [SIZE-1:0]       result,
    output logic [ITER_W-1:0]     iter_cnt
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT,
        FETCH,
        DONE,
        ERR
    } state_t;

    state_t              state;
    logic [ITER_W-1:0]   n_iter_q;
    logic [WD_W-1:0]     wd;
    logic [ITER_W-1:0]   cnt_inc;
    logic [WD_W-1:0]     wd_inc;

    always_comb begin
        cnt_inc = iter_cnt + ITER_W'(1);
        wd_inc  = wd + WD_W'(1);
    end

    // Outputs are registered: each is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            n_iter_q    <= '0;
            wd          <= '0;
            pa_en       <= 1'b0;
            digit_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            pa_a        <= '0;
            result      <= '0;
            iter_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_cnt <= '0;
                        error    <= 1'b0;
                        n_iter_q <= n_iter;
                        if (n_iter == '0) begin
                            result <= a_init[SIZE-1:0];
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            pa_a  <= a_init;
                            pa_en <= 1'b1;
                            busy  <= 1'b1;
                            state <= PULSE;
                        end
                    end
                end
                PULSE: begin
                    pa_en <= 1'b0;
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A returning result wins over a watchdog expiring in the same cycle.
                    if (pa_en_out) begin
                        result   <= pa_new_a;
                        iter_cnt <= cnt_inc;
                        if (cnt_inc == n_iter_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            digit_ready <= 1'b1;
                            state       <= FETCH;
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                FETCH: begin
                    if (digit_valid) begin
                        pa_a        <= {digit, result};
                        digit_ready <= 1'b0;
                        pa_en       <= 1'b1;
                        state       <= PULSE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_a_seq.sv
// Directed-vector bench for phase_a_seq; a negedge monitor checks pulses and completions
// against queues of hand-computed expectations pushed by the stimulus thread.
module tb_phase_a_seq;

    localparam int SIZE    = 3072;
    localparam int RADIX   = 78;
    localparam int ITER_W  = 6;
    localparam int TIMEOUT = 64;
    localparam int AW      = SIZE + RADIX + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ITER_W-1:0] n_iter;
    logic [AW-1:0]     a_init;
    logic [RADIX:0]    digit;
    logic              digit_valid;
    logic              digit_ready;
    logic              pa_en;
    logic [AW-1:0]     pa_a;
    logic [SIZE-1:0]   pa_new_a;
    logic              pa_en_out;
    logic              busy;
    logic              done;
    logic              error;
    logic [SIZE-1:0]   result;
    logic [ITER_W-1:0] iter_cnt;

    phase_a_seq #(
        .SIZE(SIZE),
        .RADIX(RADIX),
        .ITER_W(ITER_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .n_iter(n_iter),
        .a_init(a_init),
        .digit(digit),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .pa_en(pa_en),
        .pa_a(pa_a),
        .pa_new_a(pa_new_a),
        .pa_en_out(pa_en_out),
        .busy(busy),
        .done(done),
        .error(error),
        .result(result),
        .iter_cnt(iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              is_err;
        logic [SIZE-1:0]   res;
        logic [ITER_W-1:0] cnt;
    } exp_t;

    logic [AW-1:0] exp_pa_q[$];
    exp_t          exp_done_q[$];
    exp_t          mon_e;
    logic          err_q;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got top=%0h low=%0h, expected top=%0h low=%0h", name,
                     act[AW-1:SIZE], act[63:0], exp[AW-1:SIZE], exp[63:0]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ITER_W-1:0] n, input logic [AW-1:0] a);
        start  = 1'b1;
        n_iter = n;
        a_init = a;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (!pa_en && n < 100) begin
            tick(1);
            n++;
        end
        chk(name, pa_en, 1);
    endtask

    task automatic step(input string name, input int lat, input logic [SIZE-1:0] val);
        wait_en(name);
        tick(lat);
        pa_new_a  = val;
        pa_en_out = 1'b1;
        tick(1);
        pa_en_out = 1'b0;
    endtask

    initial err_q = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pa_en) begin
                if (exp_pa_q.size() == 0) chk("unexpected_pa_en", pa_en, 0);
                else chk("pa_a_at_pulse", pa_a, exp_pa_q.pop_front());
            end
            if (done || (error && !err_q)) begin
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_completion", {done, error && !err_q}, 2'b00);
                end else begin
                    mon_e = exp_done_q.pop_front();
                    chk("completion_kind", {done, error}, mon_e.is_err ? 2'b01 : 2'b10);
                    chk("completion_busy", busy, 0);
                    if (!mon_e.is_err) begin
                        chk("completion_result", result, mon_e.res);
                        chk("completion_iter_cnt", iter_cnt, mon_e.cnt);
                    end
                end
            end
        end
        err_q = error;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end, expected completion");
        $fatal(1, "timeout");
    end

    logic [SIZE-1:0] r0, r1, r2;
    logic [AW-1:0]   a3;

    initial begin
        rst_n = 1'b0; start = 1'b0; n_iter = '0; a_init = '0;
        digit = '0; digit_valid = 1'b0; pa_new_a = '0; pa_en_out = 1'b0;
        tick(3);
        chk("reset_flags", {pa_en, digit_ready, busy, done, error}, 0);
        chk("reset_pa_a", pa_a, 0);
        chk("reset_result", result, 0);
        chk("reset_iter_cnt", iter_cnt, 0);
        rst_n = 1'b1;
        tick(2);

        // Reset mid-WAIT, then a late pa_en_out that must be discarded
        exp_pa_q.push_back(AW'(9));
        do_start(2, AW'(9));
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rst_async_flags", {pa_en, digit_ready, busy, done, error}, 0);
        chk("rst_async_pa_a", pa_a, 0);
        chk("rst_async_result", result, 0);
        chk("rst_async_iter_cnt", iter_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        pa_new_a  = SIZE'(16'hDEAD);
        pa_en_out = 1'b1;
        tick(1);
        pa_en_out = 1'b0;
        chk("rst_no_capture_result", result, 0);
        chk("rst_no_capture_iter_cnt", iter_cnt, 0);
        chk("rst_idle_busy", busy, 0);
        tick(2);

        // n_iter = 1
        exp_pa_q.push_back(AW'(5));
        exp_done_q.push_back('{is_err: 1'b0, res: SIZE'(12'hABC), cnt: ITER_W'(1)});
        do_start(1, AW'(5));
        chk("n1_pa_en_T1", pa_en, 1);
        chk("n1_busy_T1", busy, 1);
        step("n1_pulse", 2, SIZE'(12'hABC));
        chk("n1_done_E1", done, 1);
        chk("n1_result_E1", result, AW'(12'hABC));
        chk("n1_iter_cnt", iter_cnt, 1);
        tick(2);

        // n_iter = 3, digits always valid
        r0 = SIZE'(32'hCAFE0001);
        r1 = SIZE'(32'hBEEF0002);
        r2 = SIZE'(32'hF00D0003);
        a3 = {79'h3, SIZE'(8'h44)};
        exp_pa_q.push_back(a3);
        exp_pa_q.push_back({79'h11, r0});
        exp_pa_q.push_back({79'h22, r1});
        exp_done_q.push_back('{is_err: 1'b0, res: r2, cnt: ITER_W'(3)});
        digit = 79'h11;
        digit_valid = 1'b1;
        do_start(3, a3);
        step("n3_pulse0", 3, r0);
        chk("n3_digit_ready_E1", digit_ready, 1);
        tick(1);
        digit = 79'h22;
        chk("n3_pulse_after_handshake", pa_en, 1);
        step("n3_pulse1", 2, r1);
        step("n3_pulse2", 2, r2);
        chk("n3_done", done, 1);
        chk("n3_iter_cnt", iter_cnt, 3);
        digit_valid = 1'b0;
        tick(2);

        // Digit stall with ignored start in WAIT and spurious pa_en_out in FETCH
        exp_pa_q.push_back(AW'(8'h66));
        exp_pa_q.push_back({79'h33, SIZE'(16'h7070)});
        exp_done_q.push_back('{is_err: 1'b0, res: SIZE'(16'h9090), cnt: ITER_W'(2)});
        do_start(2, AW'(8'h66));
        tick(2);
        start = 1'b1; n_iter = 1; a_init = AW'(12'h999);
        tick(1);
        start = 1'b0;
        chk("ign_start_busy", busy, 1);
        chk("ign_start_pa_a", pa_a, AW'(8'h66));
        pa_new_a  = SIZE'(16'h7070);
        pa_en_out = 1'b1;
        tick(1);
        pa_en_out = 1'b0;
        chk("stall_digit_ready_E1", digit_ready, 1);
        chk("stall_iter_cnt_1", iter_cnt, 1);
        pa_new_a  = SIZE'(16'h5555);
        pa_en_out = 1'b1;
        tick(1);
        pa_en_out = 1'b0;
        chk("spurious_result", result, AW'(16'h7070));
        chk("spurious_iter_cnt", iter_cnt, 1);
        for (int i = 0; i < 20; i++) begin
            chk("stall_digit_ready", digit_ready, 1);
            chk("stall_pa_en", pa_en, 0);
            chk("stall_error", error, 0);
            tick(1);
        end
        digit = 79'h33;
        digit_valid = 1'b1;
        tick(1);
        digit_valid = 1'b0;
        chk("stall_release_pa_en", pa_en, 1);
        step("stall_pulse1", 2, SIZE'(16'h9090));
        chk("stall_done", done, 1);
        chk("stall_iter_cnt_2", iter_cnt, 2);
        tick(2);

        // Watchdog: pa_en_out never returns
        exp_pa_q.push_back(AW'(8'h77));
        exp_done_q.push_back('{is_err: 1'b1, res: '0, cnt: '0});
        do_start(1, AW'(8'h77));
        tick(1);
        tick(TIMEOUT - 1);
        chk("wd_before_error", error, 0);
        chk("wd_before_busy", busy, 1);
        tick(1);
        chk("wd_error", error, 1);
        chk("wd_busy", busy, 0);
        tick(2);
        chk("wd_error_sticky", error, 1);
        exp_pa_q.push_back(AW'(8'h88));
        exp_done_q.push_back('{is_err: 1'b0, res: SIZE'(16'h1234), cnt: ITER_W'(1)});
        do_start(1, AW'(8'h88));
        chk("wd_error_cleared", error, 0);
        step("wd_recover_pulse", 2, SIZE'(16'h1234));
        chk("wd_recover_done", done, 1);
        tick(2);

        // n_iter = 0
        exp_done_q.push_back('{is_err: 1'b0, res: SIZE'(8'h7F), cnt: ITER_W'(0)});
        do_start(0, {79'h5, SIZE'(8'h7F)});
        chk("n0_done_T1", done, 1);
        chk("n0_busy_T1", busy, 0);
        chk("n0_pa_en_T1", pa_en, 0);
        chk("n0_result", result, AW'(8'h7F));
        tick(1);
        chk("n0_busy_T2", busy, 0);
        chk("n0_pa_en_T2", pa_en, 0);
        chk("n0_done_T2", done, 0);

        tick(3);
        chk("pa_queue_drained", exp_pa_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_a_seq.md
# phase_a_seq

Iteration sequencer for the radix-78 Montgomery reduction stage `phase_a`.
- Accepts a start command with an initial operand and an iteration count.
- Issues one enable pulse per reduction step to `phase_a` and holds its `a` operand stable for the whole step.
- Captures `new_a` on `en_out`, then builds the next operand from the captured result and a top digit taken from a valid/ready digit stream.
- Sits between the exponentiation/multiply controller and one `phase_a` instance. Watchdog detects a stalled datapath.

## Interface
Parameters:
- SIZE, 3072, modulus width in bits
- RADIX, 78, digit width minus one (digit is RADIX+1 bits)
- ITER_W, 6, iteration counter width
- TIMEOUT, 64, max cycles in WAIT before error

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- n_iter  in  ITER_W  number of reduction steps; sampled with start
- a_init  in  SIZE+RADIX+1  operand for step 0; sampled with start
- digit  in  RADIX+1  top digit for steps 1..n_iter-1
- digit_valid  in  1  digit present
- digit_ready  out  1  sequencer accepts digit
- pa_en  out  1  enable to phase_a.en
- pa_a  out  SIZE+RADIX+1  operand to phase_a.a
- pa_new_a  in  SIZE  phase_a.new_a
- pa_en_out  in  1  phase_a.en_out, single-cycle
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  watchdog fired; sticky
- result  out  SIZE  last captured new_a
- iter_cnt  out  ITER_W  completed steps

## Operation
- States: IDLE, PULSE, WAIT, FETCH, DONE, ERR.
- IDLE:
  - On start with n_iter==0: result<=a_init[SIZE-1:0], iter_cnt<=0, go to DONE.
  - On start otherwise: pa_a<=a_init, iter_cnt<=0, error<=0, go to PULSE.
- PULSE:
  - pa_en=1 for exactly this cycle.
  - Watchdog is cleared.
  - Go to WAIT.
- WAIT:
  - pa_en=0.
  - The watchdog counts each cycle.
  - On pa_en_out: result<=pa_new_a, iter_cnt<=iter_cnt+1. If iter_cnt+1==n_iter, go to DONE; else go to FETCH.
  - If the watchdog reaches TIMEOUT without pa_en_out: go to ERR.
- FETCH:
  - digit_ready=1.
  - On digit_valid: pa_a<={digit, result}, then go to PULSE. Digit occupies pa_a[SIZE+RADIX:SIZE]; result occupies [SIZE-1:0].
  - Waits indefinitely for digit_valid; the watchdog is not running.
- DONE: done=1, busy=0, go to IDLE.
- ERR: error=1, busy=0, go to IDLE. error stays high until the next accepted start.
- busy=1 in PULSE, WAIT and FETCH only.
- start outside IDLE is ignored.
- pa_en_out outside WAIT is ignored; no capture and no count.
- Arithmetic: no addition; the next operand is pure concatenation. iter_cnt wraps modulo 2^ITER_W, and n_iter=2^ITER_W-1 is the maximum.

## Timing
- Reset values: state IDLE; pa_en, digit_ready, busy, done and error all 0; pa_a, result and iter_cnt all 0.
- start sampled in cycle T: pa_en=1 in cycle T+1, busy=1 from T+1.
- pa_a changes only on:
  - start acceptance;
  - a FETCH handshake.
- pa_a is stable from the PULSE cycle through the pa_en_out cycle. phase_a samples `a` several cycles after its enable edge, so this hold is mandatory.
- pa_en is low for at least 2 cycles between pulses, which satisfies phase_a's two-flop edge detector. Minimum spacing is WAIT(≥1) + FETCH(≥1).
- pa_en_out in cycle E:
  - result is valid from E+1.
  - Last step: done=1 in E+1.
  - Otherwise: digit_ready=1 from E+1.
- Digit handshake in cycle F: pa_en=1 in F+1.
- Per-step overhead beyond phase_a latency: 2 cycles (PULSE plus FETCH with digit already valid).
- n_iter==0: done in T+1, busy never asserted.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronously). Any in-flight phase_a result is discarded.

## Test plan
- Reset mid-WAIT: assert rst_n low during WAIT, then release and pulse pa_en_out. Required: all outputs return to 0 with no capture, and state is IDLE.
- n_iter=1: a_init=0x5 at bit 0, model returns 0xABC. Required:
  - pa_en pulses once, in T+1;
  - result=0xABC and done=1 in the cycle after pa_en_out;
  - iter_cnt=1.
- n_iter=3 with digits 0x11 and 0x22 always valid. Required:
  - 3 pa_en pulses;
  - second pa_a={0x11, result0}, third pa_a={0x22, result1};
  - done after the 3rd pa_en_out, iter_cnt=3.
- Digit stall: hold digit_valid=0 for 20 cycles in FETCH. Required: digit_ready stays 1, pa_en stays 0 and error stays 0; pa_en fires the cycle after valid.
- Watchdog: the model never returns pa_en_out. Required: error=1 and busy=0 exactly TIMEOUT cycles after WAIT entry; next start clears error.
- Ignored events: start during WAIT and a spurious pa_en_out in FETCH. Required: no restart, result and iter_cnt unchanged.
- n_iter=0 with a_init low bits 0x7F. Required: result=0x7F and done in T+1, with pa_en and busy never asserted.
